// File: rtl/alu_seq.sv
// Operand/result sequencer in front of a combinational ALU: IDLE -> EXEC -> DONE.
// Optional accumulator operand source enabled with `define ALU_SEQ_ACC_EN.
module alu_seq #(
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [3:0] in_opcode,
`ifdef ALU_SEQ_ACC_EN
  input  logic       in_use_acc,
`endif
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_negative,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic [3:0] out_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // One cycle beyond STALL_CYCLES lets the freshly registered operands settle
  // through the external ALU before the result is captured.
  localparam logic [3:0] EXEC_LOAD = 4'(STALL_CYCLES + 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [7:0] res_q, res_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] a_sel;

`ifdef ALU_SEQ_ACC_EN
  logic [7:0] acc_q, acc_d;
  assign a_sel = in_use_acc ? acc_q : in_a;
`else
  assign a_sel = in_a;
`endif

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      flags_q  <= '0;
`ifdef ALU_SEQ_ACC_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_ACC_EN
      acc_q    <= acc_d;
`endif
    end
  end

  // NOTE: every signal gets a hold-value default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_ACC_EN
    acc_d    = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_a_d  = a_sel;
          alu_b_d  = in_b;
          alu_op_d = in_opcode;
          cnt_d    = EXEC_LOAD;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = alu_result;
          flags_d = {alu_negative, alu_overflow, alu_zero, alu_carry};
`ifdef ALU_SEQ_ACC_EN
          acc_d   = alu_result;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: two instances (STALL_CYCLES 0 and 3) with an adder ALU stub,
// random commands checked cycle by cycle against a transaction-level model.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid [2];
  logic       in_use_acc [2];
  logic       out_ready [2];
  logic [7:0] in_a [2];
  logic [7:0] in_b [2];
  logic [3:0] in_opcode [2];
  logic       in_ready_w [2];
  logic       out_valid_w [2];
  logic [7:0] alu_a_w [2];
  logic [7:0] alu_b_w [2];
  logic [3:0] alu_op_w [2];
  logic [7:0] out_result_w [2];
  logic [3:0] out_flags_w [2];
  logic [11:0] stub [2];

  int checks = 0;
  int errors = 0;
  int stall_of [2] = '{0, 3};

  // Transaction-level model state: last captured result/flags and accumulator.
  logic [7:0] res_m [2];
  logic [3:0] flags_m [2];
  logic [7:0] acc_m [2];
  logic [7:0] last_res;
  logic [3:0] last_flags;

  // Adder ALU from plain integer arithmetic; returns {N,V,Z,C,result}.
  function automatic logic [11:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int u;
    int s;
    logic [7:0] r;
    logic c, v;
    u = int'(a) + int'(b);
    s = int'($signed(a)) + int'($signed(b));
    r = 8'(u);
    c = (u > 255);
    v = (s > 127) || (s < -128);
    return {r[7], v, (r == 8'h00), c, r};
  endfunction

  assign stub[0] = ref_add(alu_a_w[0], alu_b_w[0]);
  assign stub[1] = ref_add(alu_a_w[1], alu_b_w[1]);

  alu_seq #(.STALL_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_opcode(in_opcode[0]),
`ifdef ALU_SEQ_ACC_EN
    .in_use_acc(in_use_acc[0]),
`endif
    .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_opcode(alu_op_w[0]),
    .alu_result(stub[0][7:0]), .alu_carry(stub[0][8]), .alu_zero(stub[0][9]),
    .alu_overflow(stub[0][10]), .alu_negative(stub[0][11]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
    .out_result(out_result_w[0]), .out_flags(out_flags_w[0])
  );

  alu_seq #(.STALL_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_opcode(in_opcode[1]),
`ifdef ALU_SEQ_ACC_EN
    .in_use_acc(in_use_acc[1]),
`endif
    .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_opcode(alu_op_w[1]),
    .alu_result(stub[1][7:0]), .alu_carry(stub[1][8]), .alu_zero(stub[1][9]),
    .alu_overflow(stub[1][10]), .alu_negative(stub[1][11]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
    .out_result(out_result_w[1]), .out_flags(out_flags_w[1])
  );

  // Observed snapshot {out_valid, in_ready, alu_a, alu_b, alu_opcode, out_result, out_flags}.
  function automatic logic [33:0] obs(input int d);
    return {out_valid_w[d], in_ready_w[d], alu_a_w[d], alu_b_w[d], alu_op_w[d],
            out_result_w[d], out_flags_w[d]};
  endfunction

  task automatic garbage(input int d);
    in_valid[d]   = 1'b1;
    in_a[d]       = 8'($urandom);
    in_b[d]       = 8'($urandom);
    in_opcode[d]  = 4'($urandom);
    in_use_acc[d] = 1'($urandom);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      res_m[d] = '0; flags_m[d] = '0; acc_m[d] = '0;
    end
  endtask

  // Issue one command on instance d and follow it through EXEC, DONE (hold cycles of
  // back-pressure) and release, comparing the full output snapshot every cycle.
  task automatic do_cmd(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic use_acc, input int hold);
    logic [7:0]  ea;
    logic [11:0] e;
    logic [33:0] exp_v;
    int lat;
    lat = 2 + stall_of[d];
`ifdef ALU_SEQ_ACC_EN
    ea = use_acc ? acc_m[d] : a;
`else
    ea = a;
`endif
    e = ref_add(ea, b);
    checks++;
    if (in_ready_w[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready[%0d]: in_ready=%b expected 1", d, in_ready_w[d]);
    end
    in_valid[d] = 1'b1; in_a[d] = a; in_b[d] = b; in_opcode[d] = op; in_use_acc[d] = use_acc;
    out_ready[d] = 1'($urandom);
    @(negedge clk);
    for (int k = 0; k < lat; k++) begin
      exp_v = {1'b0, 1'b0, ea, b, op, res_m[d], flags_m[d]};
      checks++;
      if (obs(d) !== exp_v) begin
        errors++;
        $display("FAIL exec[%0d] cyc %0d: got %h expected %h", d, k, obs(d), exp_v);
      end
      garbage(d);
      out_ready[d] = 1'($urandom);
      @(negedge clk);
    end
    res_m[d] = e[7:0]; flags_m[d] = e[11:8]; acc_m[d] = e[7:0];
    exp_v = {1'b1, 1'b0, ea, b, op, res_m[d], flags_m[d]};
    checks++;
    if (obs(d) !== exp_v) begin
      errors++;
      $display("FAIL done[%0d]: got %h expected %h", d, obs(d), exp_v);
    end
    last_res = out_result_w[d];
    last_flags = out_flags_w[d];
    out_ready[d] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      garbage(d);
      @(negedge clk);
      checks++;
      if (obs(d) !== exp_v) begin
        errors++;
        $display("FAIL hold[%0d] cyc %0d: got %h expected %h", d, h, obs(d), exp_v);
      end
    end
    garbage(d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    exp_v = {1'b0, 1'b1, ea, b, op, res_m[d], flags_m[d]};
    checks++;
    if (obs(d) !== exp_v) begin
      errors++;
      $display("FAIL release[%0d]: got %h expected %h", d, obs(d), exp_v);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== {1'b0, 1'b1, 32'h0}) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", d, obs(d), {1'b0, 1'b1, 32'h0});
      end
    end
  endtask

  task automatic test_directed();
    do_cmd(0, 8'h05, 8'h03, 4'h2, 1'b0, 0);
    checks++;
    if ({last_res, last_flags} !== {8'h08, 4'b0000}) begin
      errors++;
      $display("FAIL add_05_03: got %h/%b expected 08/0000", last_res, last_flags);
    end
    do_cmd(0, 8'hFF, 8'h01, 4'h5, 1'b0, 0);
    checks++;
    if ({last_res, last_flags} !== {8'h00, 4'b0011}) begin
      errors++;
      $display("FAIL add_ff_01: got %h/%b expected 00/0011", last_res, last_flags);
    end
    do_cmd(0, 8'h7F, 8'h01, 4'hA, 1'b0, 0);
    checks++;
    if ({last_res, last_flags} !== {8'h80, 4'b1100}) begin
      errors++;
      $display("FAIL add_7f_01: got %h/%b expected 80/1100", last_res, last_flags);
    end
  endtask

  task automatic test_backpressure();
    do_cmd(0, 8'h21, 8'h42, 4'h3, 1'b0, 5);
    do_cmd(0, 8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 0);
  endtask

  task automatic test_stall();
    do_cmd(1, 8'h05, 8'h03, 4'h1, 1'b0, 0);
    checks++;
    if (last_res !== 8'h08) begin
      errors++;
      $display("FAIL stall_add: got %h expected 08", last_res);
    end
    do_cmd(1, 8'h80, 8'h80, 4'h7, 1'b0, 2);
  endtask

  task automatic test_rst_exec();
    in_valid[1] = 1'b1; in_a[1] = 8'h33; in_b[1] = 8'h44; in_opcode[1] = 4'h9;
    @(negedge clk);
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (obs(1) !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rst_exec: got %h expected %h", obs(1), {1'b0, 1'b1, 32'h0});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid_w[1] !== 1'b0) begin
        errors++;
        $display("FAIL rst_exec_no_valid cyc %0d: out_valid=%b expected 0", k, out_valid_w[1]);
      end
    end
    out_ready[1] = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_cmd(i % 2, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end
  endtask

`ifdef ALU_SEQ_ACC_EN
  task automatic test_acc();
    do_cmd(0, 8'h10, 8'h20, 4'h0, 1'b0, 0);
    do_cmd(0, 8'hEE, 8'h01, 4'h0, 1'b1, 0);
    checks++;
    if (last_res !== 8'h31) begin
      errors++;
      $display("FAIL acc_chain: got %h expected 31", last_res);
    end
    test_reset();
    do_cmd(0, 8'h55, 8'h02, 4'h0, 1'b1, 0);
    checks++;
    if (last_res !== 8'h02) begin
      errors++;
      $display("FAIL acc_after_reset: got %h expected 02", last_res);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_use_acc[d] = 1'b0; out_ready[d] = 1'b0;
      in_a[d] = '0; in_b[d] = '0; in_opcode[d] = '0;
    end
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_stall();
    test_rst_exec();
    test_random();
`ifdef ALU_SEQ_ACC_EN
    test_reset();
    test_acc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
